// File: rtl/calc_disp_pkg.sv
// Shared constants, payload types and helpers for the calculator display pixel path.
package calc_disp_pkg;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DASH   = 8'h2D;

  // BBGGGRRR colour codes
  localparam logic [7:0] COL_BLACK = 8'h00;
  localparam logic [7:0] COL_WHITE = 8'hFF;
  localparam logic [7:0] COL_BLUE  = 8'hC0;
  localparam logic [7:0] COL_BG    = 8'h52;

  typedef struct packed {
    logic       video_on;
    logic       digit_hit;
    logic       cursor_hit;
    logic [2:0] col;
  } s0_flags_t;

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    return {4'h0, d};
  endfunction

  // Decimal digits needed for 2**w - 1: floor(w*log10(2)) + 1, with log10(2) ~ 1233/4096
  function automatic int unsigned bcd_nibbles(input int unsigned w);
    return ((w * 32'd1233) >> 12) + 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one adjust-and-shift per clock, VALUE_W clocks per value.
module bin2bcd_seq
  import calc_disp_pkg::*;
#(
  parameter int unsigned VALUE_W   = 14,
  parameter int unsigned N_NIBBLES = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  logic [VALUE_W-1:0]     i_bin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*N_NIBBLES-1:0] o_bcd
);

  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
  localparam int unsigned BCD_W = 4 * N_NIBBLES;

  logic [VALUE_W-1:0] r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_adj;
  logic               r_busy;
  logic               r_done;

  // Add 3 to every nibble >= 5 so the following shift carries correctly
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < int'(N_NIBBLES); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin  <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
        r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(VALUE_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/digit_field_pixel_gen.sv
// Row of scaled decimal glyphs plus crosshair cursor; the value is converted to BCD in the
// background and committed to the display registers only at frame start.
module digit_field_pixel_gen
  import calc_disp_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned VALUE_W    = 14,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int          ORIGIN_X   = 150,
  parameter int          ORIGIN_Y   = 70,
  parameter int          PITCH      = 128,
  parameter int          CURSOR_ARM = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pixel_tick,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               frame_start,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic               blank_lz,
  input  logic [9:0]         mouse_x,
  input  logic [9:0]         mouse_y,
  output logic [7:0]         rom_char,
  output logic [2:0]         rom_row,
  input  logic [7:0]         rom_data,
  output logic [7:0]         rgb
);

  localparam int          GLYPH = 8 << SCALE_LOG2;
  localparam int unsigned N_NIB = bcd_nibbles(VALUE_W);
  localparam int unsigned N_EXT = (N_NIB > N_DIGITS) ? N_NIB : N_DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nx;
  logic                  r_ready;
  logic                  w_ready_nx;
  logic                  w_start;
  logic                  w_copy;
  logic                  w_busy;
  logic                  w_done;
  logic [4*N_NIB-1:0]    w_bcd;
  logic [4*N_EXT-1:0]    w_bcd_ext;
  logic                  w_bcd_ovf;
  logic [4*N_DIGITS-1:0] r_disp;
  logic                  r_ovf;
  logic [N_DIGITS-1:0]   w_blank;
  logic                  w_lz_run;

  logic                  w_dig_hit;
  logic                  w_cur_hit;
  logic [7:0]            w_char;
  logic [2:0]            w_row;
  logic [2:0]            w_col;
  int                    w_rel_x;
  int                    w_rel_y;
  int                    w_dx;
  int                    w_dy;
  logic [7:0]            r_rom_char;
  logic [2:0]            r_rom_row;
  s0_flags_t             r_s0;
  logic                  w_glyph_bit;
  logic [7:0]            w_rgb_nx;
  logic [7:0]            r_rgb;

  bin2bcd_seq #(
    .VALUE_W   (VALUE_W),
    .N_NIBBLES (N_NIB)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_bin   (value_in),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Converter control: accept, wait for conversion, hold until a frame boundary
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_copy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (value_valid && !w_busy) begin
          w_start    = 1'b1;
          w_state_nx = ST_CONV;
        end
      end
      ST_CONV: begin
        if (w_done) w_state_nx = ST_PEND;
      end
      ST_PEND: begin
        if (pixel_tick && frame_start) begin
          w_copy     = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_ready_nx = (w_state_nx == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_ready <= w_ready_nx;
    end
  end

  // Any nonzero nibble above the displayed ones means the value does not fit
  always_comb begin
    w_bcd_ext              = '0;
    w_bcd_ext[4*N_NIB-1:0] = w_bcd;
    w_bcd_ovf              = 1'b0;
    for (int i = int'(N_DIGITS); i < int'(N_EXT); i++) begin
      if (w_bcd_ext[4*i +: 4] != 4'd0) w_bcd_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else if (w_copy) begin
      r_disp <= w_bcd_ext[4*N_DIGITS-1:0];
      r_ovf  <= w_bcd_ovf;
    end
  end

  // Digit 0 is most significant; the least significant digit is never blanked
  always_comb begin
    w_lz_run = blank_lz;
    w_blank  = '0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      w_lz_run   = w_lz_run && (r_disp[4*(int'(N_DIGITS)-1-k) +: 4] == 4'd0);
      w_blank[k] = w_lz_run && (k != int'(N_DIGITS) - 1);
    end
  end

  // S0: hit tests in signed arithmetic so nothing wraps at the screen edges
  always_comb begin
    w_dig_hit = 1'b0;
    w_char    = CH_SPACE;
    w_row     = '0;
    w_col     = '0;
    w_rel_x   = 0;
    w_rel_y   = int'(pixel_y) - ORIGIN_Y;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      w_rel_x = int'(pixel_x) - (ORIGIN_X + k * PITCH);
      if (w_rel_y >= 0 && w_rel_y < GLYPH && w_rel_x >= 0 && w_rel_x < GLYPH) begin
        w_dig_hit = 1'b1;
        w_row     = 3'(w_rel_y >>> SCALE_LOG2);
        w_col     = 3'(w_rel_x >>> SCALE_LOG2);
        if (r_ovf)           w_char = CH_DASH;
        else if (w_blank[k]) w_char = CH_SPACE;
        else                 w_char = digit_code(r_disp[4*(int'(N_DIGITS)-1-k) +: 4]);
      end
    end
    w_dx      = int'(pixel_x) - int'(mouse_x);
    w_dy      = int'(pixel_y) - int'(mouse_y);
    w_cur_hit = ((w_dx >= -CURSOR_ARM) && (w_dx <= CURSOR_ARM) && (pixel_y == mouse_y)) ||
                ((w_dy >= -CURSOR_ARM) && (w_dy <= CURSOR_ARM) && (pixel_x == mouse_x));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_char <= CH_SPACE;
      r_rom_row  <= '0;
      r_s0       <= '0;
    end else if (pixel_tick) begin
      r_rom_char <= w_char;
      r_rom_row  <= w_row;
      r_s0       <= '{video_on: video_on, digit_hit: w_dig_hit, cursor_hit: w_cur_hit, col: w_col};
    end
  end

  // S1: ROM row bit 7 is the leftmost glyph column
  always_comb begin
    w_glyph_bit = rom_data[~r_s0.col];
    if (!r_s0.video_on)                  w_rgb_nx = COL_BLACK;
    else if (r_s0.cursor_hit)            w_rgb_nx = COL_WHITE;
    else if (r_s0.digit_hit && w_glyph_bit) w_rgb_nx = COL_BLUE;
    else if (r_s0.digit_hit)             w_rgb_nx = COL_BLACK;
    else                                 w_rgb_nx = COL_BG;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_rgb <= 8'h00;
    else if (pixel_tick) r_rgb <= w_rgb_nx;
  end

  assign value_ready = r_ready;
  assign rom_char    = r_rom_char;
  assign rom_row     = r_rom_row;
  assign rgb         = r_rgb;

endmodule

// File: tb/tb_digit_field_pixel_gen.sv
// Directed bench for digit_field_pixel_gen with a reference pixel model and an rgb scoreboard.
module tb_digit_field_pixel_gen;

  localparam int N = 4;
  localparam logic [7:0] T_SPACE = 8'h20;
  localparam logic [7:0] T_DASH  = 8'h2D;
  localparam logic [7:0] T_BLACK = 8'h00;
  localparam logic [7:0] T_WHITE = 8'hFF;
  localparam logic [7:0] T_BLUE  = 8'hC0;
  localparam logic [7:0] T_BG    = 8'h52;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        frame_start = 1'b0;
  logic [13:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        blank_lz = 1'b0;
  logic [9:0]  mouse_x = 10'd1000;
  logic [9:0]  mouse_y = 10'd1000;
  logic [7:0]  rom_char;
  logic [2:0]  rom_row;
  logic [7:0]  rom_data;
  logic [7:0]  rgb;

  int          n_vec = 0;
  int          n_miss = 0;
  int          tb_dig [N];
  bit          tb_ovf = 1'b0;
  logic [7:0]  q_rgb [$];
  string       q_tag [$];
  logic [7:0]  last_rgb = 8'h00;
  logic [7:0]  last_char = 8'h20;
  logic [2:0]  last_row = 3'd0;

  always #5 clk = ~clk;

  // Stand-in character ROM: space is empty, other codes give a row-dependent pattern with bit7 set
  function automatic logic [7:0] tb_rom(input logic [7:0] c, input logic [2:0] r);
    return (c == T_SPACE) ? 8'h00 : {1'b1, r, c[3:0]};
  endfunction

  assign rom_data = tb_rom(rom_char, rom_row);

  digit_field_pixel_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pixel_tick  (pixel_tick),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_lz    (blank_lz),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .rom_char    (rom_char),
    .rom_row     (rom_row),
    .rom_data    (rom_data),
    .rgb         (rgb)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: geometry 150 + 128*k, glyph 64x64 from y=70, 8x magnification, arm 4
  function automatic void model(input int x, input int y, input bit vo,
                                output logic [7:0] ch, output logic [2:0] row,
                                output logic [7:0] col_rgb, output bit hit);
    int k_hit = -1;
    bit run;
    bit cur;
    int mx = int'(mouse_x);
    int my = int'(mouse_y);
    logic [2:0] col = 3'd0;
    logic [7:0] bits;
    ch  = T_SPACE;
    row = 3'd0;
    for (int k = 0; k < N; k++)
      if (x >= 150 + 128*k && x < 214 + 128*k && y >= 70 && y < 134) k_hit = k;
    hit = (k_hit >= 0);
    if (hit) begin
      row = 3'((y - 70) / 8);
      col = 3'((x - 150 - 128*k_hit) / 8);
      run = blank_lz;
      for (int k = 0; k <= k_hit; k++) run = run && (tb_dig[k] == 0);
      if (tb_ovf)                     ch = T_DASH;
      else if (run && k_hit != N - 1) ch = T_SPACE;
      else                            ch = 8'(tb_dig[k_hit]);
    end
    cur  = ((x - mx <= 4) && (mx - x <= 4) && (y == my)) ||
           ((y - my <= 4) && (my - y <= 4) && (x == mx));
    bits = tb_rom(ch, row);
    if (!vo)                       col_rgb = T_BLACK;
    else if (cur)                  col_rgb = T_WHITE;
    else if (hit && bits[7 - col]) col_rgb = T_BLUE;
    else if (hit)                  col_rgb = T_BLACK;
    else                           col_rgb = T_BG;
  endfunction

  // One pixel tick: check S0 ROM request now, score rgb of the previous pixel
  task automatic px(input int x, input int y, input bit vo, input bit fs);
    logic [7:0] ec;
    logic [2:0] er;
    logic [7:0] eg;
    bit         hit;
    @(negedge clk);
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    video_on    = vo;
    frame_start = fs;
    pixel_tick  = 1'b1;
    model(x, y, vo, ec, er, eg, hit);
    q_rgb.push_back(eg);
    q_tag.push_back($sformatf("rgb(%0d,%0d)", x, y));
    @(posedge clk);
    #1;
    pixel_tick  = 1'b0;
    frame_start = 1'b0;
    if (hit) begin
      check8($sformatf("rom_char(%0d,%0d)", x, y), rom_char, ec);
      check8($sformatf("rom_row(%0d,%0d)", x, y), {5'd0, rom_row}, {5'd0, er});
      last_char = ec;
      last_row  = er;
    end
    if (q_rgb.size() == 2) begin
      last_rgb = q_rgb.pop_front();
      check8(q_tag.pop_front(), rgb, last_rgb);
    end
  endtask

  task automatic probe_digits();
    for (int k = 0; k < N; k++) begin
      px(150 + 128*k, 70, 1'b1, 1'b0);
      px(213 + 128*k, 133, 1'b1, 1'b0);
    end
    px(800, 400, 1'b1, 1'b0);
  endtask

  task automatic load(input int v);
    @(negedge clk);
    check8("ready_before_load", {7'd0, value_ready}, 8'd1);
    value_in    = 14'(v);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    check8("ready_low_after_accept", {7'd0, value_ready}, 8'd0);
  endtask

  task automatic commit(input int v);
    repeat (20) @(negedge clk);
    check8("ready_low_in_pend", {7'd0, value_ready}, 8'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check8("frame_without_tick", {7'd0, value_ready}, 8'd0);
    px(800, 400, 1'b1, 1'b1);
    @(negedge clk);
    check8("ready_after_frame", {7'd0, value_ready}, 8'd1);
    tb_ovf = (v >= 10000);
    for (int k = 0; k < N; k++) tb_dig[k] = (v / (10 ** (N - 1 - k))) % 10;
  endtask

  initial begin
    for (int k = 0; k < N; k++) tb_dig[k] = 0;
    repeat (3) @(negedge clk);
    check8("reset_rgb", rgb, 8'h00);
    check8("reset_ready", {7'd0, value_ready}, 8'd1);
    check8("reset_rom_char", rom_char, T_SPACE);
    check8("reset_rom_row", {5'd0, rom_row}, 8'd0);
    reset_n = 1'b1;

    probe_digits();

    // 1234, with an ignored valid while the result is pending; old digits until the frame
    load(1234);
    repeat (18) @(negedge clk);
    value_in    = 14'd9999;
    value_valid = 1'b1;
    repeat (2) @(negedge clk);
    value_valid = 1'b0;
    px(150, 70, 1'b1, 1'b0);
    commit(1234);
    probe_digits();

    blank_lz = 1'b1;
    load(7);
    commit(7);
    probe_digits();
    blank_lz = 1'b0;
    probe_digits();

    load(12000);
    commit(12000);
    probe_digits();

    blank_lz = 1'b1;
    load(0);
    commit(0);
    probe_digits();
    blank_lz = 1'b0;

    // Glyph boundaries and video_on
    px(214, 70, 1'b1, 1'b0);
    px(213, 133, 1'b1, 1'b0);
    px(150, 134, 1'b1, 1'b0);
    px(149, 70, 1'b1, 1'b0);
    px(150, 69, 1'b1, 1'b0);
    px(277, 100, 1'b1, 1'b0);
    px(278, 100, 1'b1, 1'b0);
    px(150, 70, 1'b0, 1'b0);

    // Cursor arms near the screen edge and over a digit
    mouse_x = 10'd2;
    mouse_y = 10'd2;
    px(0, 2, 1'b1, 1'b0);
    px(1023, 2, 1'b1, 1'b0);
    px(2, 6, 1'b1, 1'b0);
    px(2, 7, 1'b1, 1'b0);
    px(6, 2, 1'b1, 1'b0);
    px(7, 2, 1'b1, 1'b0);
    px(2, 1023, 1'b1, 1'b0);
    mouse_x = 10'd160;
    mouse_y = 10'd80;
    px(160, 80, 1'b1, 1'b0);
    px(164, 80, 1'b1, 1'b0);
    px(161, 81, 1'b1, 1'b0);
    mouse_x = 10'd1000;
    mouse_y = 10'd1000;
    px(150, 70, 1'b1, 1'b0);
    px(150, 70, 1'b1, 1'b0);

    // Without pixel_tick the pixel path holds
    @(negedge clk);
    pixel_x  = 10'd500;
    pixel_y  = 10'd300;
    video_on = 1'b0;
    repeat (3) @(negedge clk);
    check8("hold_rgb", rgb, last_rgb);
    check8("hold_rom_char", rom_char, last_char);
    check8("hold_rom_row", {5'd0, rom_row}, {5'd0, last_row});

    // Reset in the middle of a conversion
    px(800, 400, 1'b1, 1'b0);
    px(800, 400, 1'b1, 1'b0);
    load(5555);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check8("midconv_reset_rgb", rgb, 8'h00);
    check8("midconv_reset_ready", {7'd0, value_ready}, 8'd1);
    check8("midconv_reset_rom_char", rom_char, T_SPACE);
    q_rgb.delete();
    q_tag.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tb_ovf  = 1'b0;
    for (int k = 0; k < N; k++) tb_dig[k] = 0;
    @(negedge clk);
    check8("ready_after_reset", {7'd0, value_ready}, 8'd1);
    probe_digits();
    px(900, 500, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
